alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter OP_ADD, default 6'h08, ALU op code for add with carry-in forced 0.
REQ-002 SHALL have parameter OP_INC, default 6'h2A, ALU op code for increment of port b.
REQ-003 SHALL have parameter OP_DEC, default 6'h2B, ALU op code for decrement of port b.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports x_valid in 1, x_ready out 1: execute requester handshake.
REQ-007 SHALL have ports x_op in 6, x_a in 8, x_b in 8, x_ci in 1: execute ALU operands.
REQ-008 SHALL have ports x_rvalid out 1, x_out out 8, x_status out 8: execute result (N=7, V=6, Z=1, C=0).
REQ-009 SHALL have ports g_valid in 1, g_ready out 1: address-generator requester handshake.
REQ-010 SHALL have ports g_base in 16, g_off in 8, g_signed in 1: base address, offset, offset is two's complement.
REQ-011 SHALL have ports g_rvalid out 1, g_addr out 16, g_fix out 1: effective address and page-crossed flag.
REQ-012 SHALL have ports alu_op out 6, alu_ai out 8, alu_bi out 8, alu_ci out 1: ALU drive.
REQ-013 SHALL have ports alu_out in 8, alu_status in 8, alu_bpage in 1: ALU results, registered, valid one cycle after issue.

Function
REQ-014 One ALU issue slot per cycle; issue = drive alu_* in cycle T; results sampled in T+1.
REQ-015 Idle slot: alu_op, alu_ai, alu_bi, alu_ci driven 0.
REQ-016 Transfer on valid&ready; payload sampled only on transfer.
REQ-017 Execute: transfer at T issues x_op/x_a/x_b/x_ci at T; x_rvalid pulses at T+1; x_out=alu_out, x_status=alu_status in that cycle.
REQ-018 Generator FSM states G_IDLE, G_LO, G_HI, G_DONE; g_ready=0 outside G_IDLE.
REQ-019 G_IDLE + g transfer at T: issue OP_ADD, ai=g_base[7:0], bi=g_off, ci=0; capture g_base[15:8], g_off[7], g_signed; go G_LO.
REQ-020 G_LO: fix = g_signed ? alu_bpage : alu_status[0]; capture low byte alu_out.
REQ-021 G_LO, fix=0: go G_DONE, address={base_hi, low}, g_fix=0; slot free for execute.
REQ-022 G_LO, fix=1: issue OP_INC (unsigned, or signed with off[7]=0) or OP_DEC (signed, off[7]=1), bi=base_hi; go G_HI; slot owned by generator.
REQ-023 G_HI: address={alu_out, low}, g_fix=1; go G_DONE.
REQ-024 G_DONE: g_rvalid=1 for exactly one cycle with g_addr/g_fix stable; go G_IDLE; latency 2 cycles (no fix) or 3 cycles (fix) after transfer.
REQ-025 Responses have no backpressure; g_addr/g_fix hold last value when g_rvalid=0.
REQ-026 Slot priority: generator fix issue (G_LO, fix=1) > arbitration between x and new g request.
REQ-027 x_ready=1 iff slot not taken by fix issue and x wins arbitration; g_ready=1 iff G_IDLE and g wins; loser sees ready=0 and holds request.
REQ-028 Execute may transfer in the G_LO (fix=0), G_HI and G_DONE cycles; back-to-back x transfers every cycle allowed.
REQ-029 Arbitration uses no combinational path from ready to the same requester's valid.

Reset
REQ-030 Asserted: FSM G_IDLE, x_rvalid=0, g_rvalid=0, g_addr=0, g_fix=0, RR pointer favours x, alu_* driven 0.
REQ-031 Reset mid-sequence drops the outstanding request; no rvalid pulse afterward; g_ready=1 in first cycle after release.

Configuration
REQ-032 ALU_ARB_RR_EN defined: round-robin between x and g on new requests; pointer toggles to the other requester after each grant of a contended slot.
REQ-033 ALU_ARB_RR_EN undefined: fixed priority, x always wins over new g; g may starve while x_valid held.

Verification
REQ-034 x_op=8'h18 ADC, x_a=8'h50, x_b=8'h50, x_ci=0 -> T+1 x_rvalid=1, x_out=8'hA0, N=1 V=1 Z=0 C=0.
REQ-035 g_base=16'h1210, g_off=8'h05, g_signed=0 -> T+2 g_addr=16'h1215, g_fix=0, one ALU issue.
REQ-036 g_base=16'h12F0, g_off=8'h20, g_signed=0 -> OP_INC issued T+1, T+3 g_addr=16'h1310, g_fix=1.
REQ-037 g_base=16'h1205, g_off=8'hF0, g_signed=1 -> OP_DEC issued T+1, T+3 g_addr=16'h11F5, g_fix=1.
REQ-038 x_valid and g_valid held high 8 cycles -> RR_EN: grants alternate, x stalled in fix cycle; no RR_EN: g never granted.
REQ-039 Reset asserted during G_HI -> g_rvalid never pulses; all outputs per REQ-030; g_ready=1 after release.

Source files
------------

// File: rtl/alu_arb.sv
// alu_arb: shares one ALU issue slot between an execute requester (x) and an
// effective-address generator (g). The generator adds base low byte + offset,
// then, if the page is crossed, spends a second slot fixing the high byte.
// Optional feature macro: ALU_ARB_RR_EN (round-robin between x and new g
// requests). Without it x has fixed priority over new g requests.
module alu_arb #(
  parameter logic [5:0] OP_ADD = 6'h08,
  parameter logic [5:0] OP_INC = 6'h2A,
  parameter logic [5:0] OP_DEC = 6'h2B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [5:0]  x_op,
  input  logic [7:0]  x_a,
  input  logic [7:0]  x_b,
  input  logic        x_ci,
  output logic        x_rvalid,
  output logic [7:0]  x_out,
  output logic [7:0]  x_status,
  input  logic        g_valid,
  output logic        g_ready,
  input  logic [15:0] g_base,
  input  logic [7:0]  g_off,
  input  logic        g_signed,
  output logic        g_rvalid,
  output logic [15:0] g_addr,
  output logic        g_fix,
  output logic [5:0]  alu_op,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_status,
  input  logic        alu_bpage
);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_LO   = 2'd1,
    G_HI   = 2'd2,
    G_DONE = 2'd3
  } g_state_e;

  g_state_e    state_q, state_d;
  logic [7:0]  base_hi_q, base_hi_d;
  logic        off_neg_q, off_neg_d;
  logic        signed_q, signed_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] addr_q, addr_d;
  logic        fix_q, fix_d;
  logic        g_rvalid_q, g_rvalid_d;
  logic        x_rvalid_q, x_rvalid_d;
  logic        rr_g_q, rr_g_d;      // 1: next contended slot goes to g

  logic        idle_s;
  logic        fix_s;
  logic        fix_issue_s;
  logic        x_xfer_s;
  logic        g_xfer_s;

  // ALU results come from the ALU's own registers, so the x result is the
  // ALU output in the cycle after issue.
  assign x_out    = alu_out;
  assign x_status = alu_status;
  assign x_rvalid = x_rvalid_q;
  assign g_rvalid = g_rvalid_q;
  assign g_addr   = addr_q;
  assign g_fix    = fix_q;

  // Arbitration, slot mux and generator next-state logic.
  always_comb begin
    state_d    = state_q;
    base_hi_d  = base_hi_q;
    off_neg_d  = off_neg_q;
    signed_d   = signed_q;
    low_d      = low_q;
    addr_d     = addr_q;
    fix_d      = fix_q;
    rr_g_d     = rr_g_q;
    g_rvalid_d = 1'b0;
    alu_op     = 6'h00;
    alu_ai     = 8'h00;
    alu_bi     = 8'h00;
    alu_ci     = 1'b0;

    idle_s      = (state_q == G_IDLE);
    // Signed offsets cross a page differently from unsigned ones; the ALU
    // reports that case on alu_bpage, otherwise the carry decides.
    fix_s       = signed_q ? alu_bpage : alu_status[0];
    fix_issue_s = (state_q == G_LO) && fix_s;

    // Ready never depends on the requester's own valid.
`ifdef ALU_ARB_RR_EN
    x_ready = !fix_issue_s && !(g_valid && idle_s && rr_g_q);
    g_ready = idle_s && !(x_valid && !rr_g_q);
`else
    x_ready = !fix_issue_s;
    g_ready = idle_s && !x_valid;
`endif

    x_xfer_s   = x_valid && x_ready;
    g_xfer_s   = g_valid && g_ready;
    x_rvalid_d = x_xfer_s;

`ifdef ALU_ARB_RR_EN
    if (x_valid && g_valid && idle_s) begin
      rr_g_d = !rr_g_q;
    end else begin
      rr_g_d = rr_g_q;
    end
`endif

    // The high-byte fix owns the slot ahead of any new request.
    if (fix_issue_s) begin
      alu_op = (signed_q && off_neg_q) ? OP_DEC : OP_INC;
      alu_bi = base_hi_q;
    end else if (x_xfer_s) begin
      alu_op = x_op;
      alu_ai = x_a;
      alu_bi = x_b;
      alu_ci = x_ci;
    end else if (g_xfer_s) begin
      alu_op = OP_ADD;
      alu_ai = g_base[7:0];
      alu_bi = g_off;
    end else begin
      alu_op = 6'h00;
    end

    case (state_q)
      G_IDLE: begin
        if (g_xfer_s) begin
          base_hi_d = g_base[15:8];
          off_neg_d = g_off[7];
          signed_d  = g_signed;
          state_d   = G_LO;
        end else begin
          state_d = G_IDLE;
        end
      end
      G_LO: begin
        low_d = alu_out;
        if (fix_s) begin
          state_d = G_HI;
        end else begin
          addr_d     = {base_hi_q, alu_out};
          fix_d      = 1'b0;
          g_rvalid_d = 1'b1;
          state_d    = G_DONE;
        end
      end
      G_HI: begin
        addr_d     = {alu_out, low_q};
        fix_d      = 1'b1;
        g_rvalid_d = 1'b1;
        state_d    = G_DONE;
      end
      G_DONE: begin
        state_d = G_IDLE;
      end
      default: begin
        state_d = G_IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= G_IDLE;
      base_hi_q  <= 8'h00;
      off_neg_q  <= 1'b0;
      signed_q   <= 1'b0;
      low_q      <= 8'h00;
      addr_q     <= 16'h0000;
      fix_q      <= 1'b0;
      g_rvalid_q <= 1'b0;
      x_rvalid_q <= 1'b0;
      rr_g_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_hi_q  <= base_hi_d;
      off_neg_q  <= off_neg_d;
      signed_q   <= signed_d;
      low_q      <= low_d;
      addr_q     <= addr_d;
      fix_q      <= fix_d;
      g_rvalid_q <= g_rvalid_d;
      x_rvalid_q <= x_rvalid_d;
      rr_g_q     <= rr_g_d;
    end
  end

endmodule
